// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a 2-entry
// instruction FIFO toward decode, with redirect flush and stale-response dropping.
// Optional feature: define FETCH_FAULT_EN to trap misaligned redirect targets
// (fetch halts with a sticky o_fault until reset).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_fault
);

  localparam logic [1:0] BUF_DEPTH = 2'd2;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrop, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        stale_q, stale_d;
  logic        fault_pend_q, fault_pend_d;
  logic        run_q;

  logic [31:0] buf_pc_q   [2];
  logic [31:0] buf_inst_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_d;

  logic        redir_take;
  logic        redir_misalign;
  logic        fault_now;
  logic        fault_any;
  logic [31:0] redir_target;
  logic        push;
  logic        pop;

  // HALT ignores redirects entirely.
  assign redir_take   = i_redirect && (state_q != StHalt);
  assign redir_target = i_redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_FAULT_EN
  assign redir_misalign = (i_redirect_pc[1:0] != 2'b00);
`else
  assign redir_misalign = 1'b0;
`endif

  assign fault_now = redir_take && redir_misalign;
  assign fault_any = fault_pend_q || fault_now;

  // A flush on the same edge beats both push and pop.
  assign push = (state_q == StWait) && i_mem_rvalid && !redir_take;
  assign pop  = o_valid && i_ready && !redir_take;

  // Buffer occupancy after this edge's push/pop.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  // Fetch FSM next state and fetch PC bookkeeping.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_addr_d   = req_addr_q;
    stale_d      = stale_q;
    fault_pend_d = fault_pend_q || fault_now;

    if (redir_take) begin
      fetch_pc_d = redir_target;
    end

    unique case (state_q)
      StIdle: begin
        if (redir_take) begin
          state_d = fault_now ? StHalt : StReq;
        end else if (run_q && (count_q < BUF_DEPTH) && !fault_pend_q) begin
          state_d = StReq;
        end
      end
      StReq: begin
        // Address must stay put until accepted, so a redirect here only marks it stale.
        if (redir_take) begin
          stale_d = 1'b1;
        end
        if (i_mem_ready) begin
          stale_d = 1'b0;
          if (stale_q || redir_take) begin
            state_d = StDrop;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        if (redir_take) begin
          if (i_mem_rvalid) begin
            state_d = fault_any ? StHalt : StReq;
          end else begin
            state_d = StDrop;
          end
        end else if (i_mem_rvalid) begin
          state_d = (count_d < BUF_DEPTH) ? StReq : StIdle;
        end
      end
      StDrop: begin
        if (i_mem_rvalid) begin
          state_d = fault_any ? StHalt : StReq;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Latch the request address only on entry into REQ.
    if ((state_d == StReq) && (state_q != StReq)) begin
      req_addr_d = fetch_pc_d;
    end
  end

  // FSM and fetch PC registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      req_addr_q   <= '0;
      stale_q      <= 1'b0;
      fault_pend_q <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_addr_q   <= req_addr_d;
      stale_q      <= stale_d;
      fault_pend_q <= fault_pend_d;
      run_q        <= 1'b1;
    end
  end

  // Instruction FIFO storage and pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_pc_q[i]   <= '0;
        buf_inst_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (redir_take) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        buf_pc_q[wr_ptr_q]   <= req_addr_q;
        buf_inst_q[wr_ptr_q] <= i_mem_rdata;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign o_valid    = (count_q != 2'd0);
  assign o_inst     = o_valid ? buf_inst_q[rd_ptr_q] : '0;
  assign o_pc       = o_valid ? buf_pc_q[rd_ptr_q] : '0;
  assign o_mem_req  = (state_q == StReq);
  assign o_mem_addr = o_mem_req ? req_addr_q : '0;

`ifdef FETCH_FAULT_EN
  assign o_fault = (state_q == StHalt);
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, fixed 2: instruction buffer entries (not overridable).
REQ-003 Port i_clk  in  1: single clock, all state on rising edge.
REQ-004 Port i_rst_n  in  1: reset, asynchronous assert, active-low.
REQ-005 Port o_mem_req  out  1: instruction memory request valid.
REQ-006 Port o_mem_addr  out  32: request word address.
REQ-007 Port i_mem_ready  in  1: memory accepts request this cycle.
REQ-008 Port i_mem_rvalid  in  1: read data valid, at least 1 cycle after acceptance.
REQ-009 Port i_mem_rdata  in  32: fetched instruction word.
REQ-010 Port i_redirect  in  1: branch/jump redirect pulse.
REQ-011 Port i_redirect_pc  in  32: redirect target.
REQ-012 Port o_inst  out  32: instruction to decode stage.
REQ-013 Port o_pc  out  32: address of o_inst.
REQ-014 Port o_valid  out  1: o_inst/o_pc valid.
REQ-015 Port i_ready  in  1: decode stage accepts o_inst.
REQ-016 Port o_fault  out  1: sticky misaligned-redirect fault.

Function
REQ-017 States IDLE, REQ, WAIT, DROP, HALT; o_mem_req SHALL equal (state==REQ), registered.
REQ-018 IDLE->REQ when buffer count < 2 and no fault pending; else stay IDLE.
REQ-019 In REQ, o_mem_addr = fetch PC, held stable until i_mem_ready; on acceptance fetch PC += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) and go WAIT.
REQ-020 At most one request outstanding at any time.
REQ-021 WAIT + i_mem_rvalid: push {addr, rdata} into buffer; next state REQ if count after push < 2, else IDLE.
REQ-022 Buffer is FIFO; o_valid = (count != 0); o_inst/o_pc SHALL show head entry; pop on o_valid && i_ready.
REQ-023 Simultaneous push and pop SHALL keep count unchanged and preserve order; push never occurs when full (guaranteed by REQ-018/021).
REQ-024 Redirect, any state: buffer flushed same edge, fetch PC <= i_redirect_pc; o_valid 0 next cycle.
REQ-025 Redirect in IDLE -> REQ (space now free); in REQ -> handshake completes at stale address, then DROP; in WAIT without rvalid -> DROP; in WAIT with rvalid same cycle -> response discarded, go REQ.
REQ-026 DROP: discard next i_mem_rvalid, then REQ (or HALT if fault pending); further redirects in DROP update fetch PC, stay DROP.
REQ-027 Redirect coincident with pop: flush wins; popped entry is considered consumed.
REQ-028 Stale responses SHALL never reach o_inst.

Reset
REQ-029 On i_rst_n low, immediately: state IDLE, fetch PC = RESET_PC, count 0, o_valid 0, o_mem_req 0, o_fault 0; o_mem_addr/o_inst/o_pc 0.
REQ-030 Reset mid-transaction abandons outstanding request; bench must not return rvalid for it after release.
REQ-031 First o_mem_req rises on second rising edge after i_rst_n release.

Configuration
REQ-032 Macro FETCH_FAULT_EN defined: redirect with i_redirect_pc[1:0] != 0 flushes buffer, sets fault pending, drains any outstanding response (DROP), then HALT; HALT asserts o_fault=1, no requests, o_valid 0, ignores redirects until reset.
REQ-033 FETCH_FAULT_EN undefined: i_redirect_pc[1:0] forced to 2'b00, HALT unreachable, o_fault tied 0.

Verification
REQ-034 Reset release, RESET_PC=0x100, memory ready always, rvalid 1 cycle later, i_ready=1 -> o_pc sequence 0x100, 0x104, 0x108, matching rdata.
REQ-035 i_ready=0, memory returns 0xAAAA0001, 0xAAAA0002 -> o_valid held, requests stop after 2 entries; i_ready=1 -> both delivered in order, fetch resumes at PC+8.
REQ-036 Redirect to 0x2000 while WAIT for 0x108 -> response for 0x108 dropped, next o_mem_addr 0x2000, first o_pc 0x2000.
REQ-037 Fetch PC 0xFFFF_FFFC -> next request address 0x0000_0000.
REQ-038 FETCH_FAULT_EN, redirect to 0x2002 -> o_fault 1, o_mem_req 0 thereafter, o_valid 0; without macro -> fetch at 0x2000, o_fault 0.
REQ-039 Assert i_rst_n low during WAIT with full buffer -> all outputs to reset values without clock edge.
